risci_mem_arbiter: RTL and testbench
====================================

Name: risci_mem_arbiter

Overview:
- Arbiter and sequencer for the core's single shared memory port.
- Two requesters share the port: the fetch stage (instruction reads) and the memory-access stage (data loads/stores).
- Grants one requester at a time and drives one outstanding memory transaction.
- Returns the response to its owner. Enforces bounded fetch starvation.

Parameters:
- VLEN, 64, address width.
- DLEN, 64, data bus width.
- ILEN, 32, instruction width; DLEN must equal 2*ILEN.
- STARVE_MAX, 4, max consecutive data grants while i_req is pending; range 1..15.
- TIMEOUT, 16, watchdog limit in cycles; used only with the optional feature; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  VLEN  fetch address; 4-byte aligned.
- i_gnt  out  1  fetch grant.
- i_valid  out  1  fetch response strobe.
- i_data  out  ILEN  fetched instruction.
- d_req  in  1  data request; held with fields stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  VLEN  data address.
- d_wdata  in  DLEN  store data.
- d_len  in  2  access size code, passed through.
- d_gnt  out  1  data grant.
- d_valid  out  1  data response strobe; pulses for loads and stores.
- d_rdata  out  DLEN  load data; 0 for stores.
- m_addr  out  VLEN  memory address.
- m_re  out  1  memory read enable.
- m_we  out  1  memory write enable.
- m_wdata  out  DLEN  memory write data.
- m_len  out  2  memory access size.
- m_rdata  in  DLEN  memory read data; valid with m_ack.
- m_ack  in  1  memory completion.
- err  out  1  timeout pulse (optional feature); constant 0 otherwise.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset: state IDLE, starve count 0, watchdog 0. All outputs 0, including m_addr, m_wdata, m_len, i_data and d_rdata.
- IDLE arbitration (Mealy grant, combinational from state, req and starve count):
  - Data wins if d_req is high and not starving fetch.
  - Starving means i_req is high and starve count == STARVE_MAX.
  - Otherwise fetch wins if i_req is high.
  - At most one of i_gnt/d_gnt is high per cycle. Grants are 0 outside IDLE.
- On a grant edge:
  - Request fields are latched into m_addr/m_wdata/m_len.
  - Fetch grant: m_re <= 1, m_len <= 2'b10.
  - Data grant: m_re <= !d_we, m_we <= d_we.
  - State moves to BUSY_I or BUSY_D. The requester drops req after seeing the grant at that edge.
- Starve count:
  - Increments (saturating) on a data grant while i_req is high.
  - Clears on any fetch grant, or when i_req is low in IDLE.
- BUSY_x holds m_* stable until m_ack. On the m_ack edge:
  - m_re/m_we <= 0 and state <= IDLE.
  - BUSY_I: i_valid <= 1, i_data <= m_rdata[63:32] if the latched addr[2] is 1, else m_rdata[31:0].
  - BUSY_D: d_valid <= 1, d_rdata <= m_rdata for a load, 0 for a store.
- i_valid/d_valid are single-cycle pulses. Data outputs hold until the next response.
- Latency: grant at cycle 0 -> m_re/m_we high at cycle 1. Ack at cycle k>=1 -> valid at cycle k+1.
- Back-to-back: a new grant may occur in the valid cycle. The minimum period is 2 cycles per transaction.
- m_ack in IDLE is ignored.
- Reset mid-transaction: the transaction is abandoned, no valid is issued, and a later m_ack is ignored.
- Only one outstanding transaction; no pipelining.

Optional Feature:
- Macro: RISCI_ARB_TIMEOUT_EN.
- Enabled:
  - The watchdog counts cycles in BUSY_x and clears on entry to BUSY_x.
  - If it reaches TIMEOUT without m_ack: m_re/m_we <= 0, state <= IDLE, err pulses 1 cycle.
  - The owner's valid pulses with data 0.
  - If m_ack arrives in the same cycle as expiry, the ack wins and err stays 0.
- Disabled: no watchdog; BUSY waits indefinitely; err tied 0.

Test Plan:
- Fetch only, memory acks 2 cycles after m_re:
  - i_req with i_addr=0x1004, m_rdata=0xAAAA_BBBB_CCCC_DDDD.
  - Expect i_gnt at cycle 0, m_re cycles 1-2, i_valid at cycle 3, i_data=0xAAAABBBB.
- Store, immediate ack:
  - d_req, d_we=1, d_addr=0x2000, d_wdata=0x1122334455667788.
  - Expect m_we=1 with those values, d_valid 1 cycle, d_rdata=0, m_re=0 throughout.
- Simultaneous i_req and d_req, count 0: d_gnt first. The next IDLE grants data again, up to STARVE_MAX=4 data grants. The 5th grant goes to fetch; the count then returns to 0.
- Reset asserted in BUSY_D, ack 1 cycle later:
  - Expect m_re=m_we=0 after the reset edge.
  - No d_valid is issued; the ack is ignored; state is IDLE.
- RISCI_ARB_TIMEOUT_EN, TIMEOUT=16, load, no ack:
  - Expect err and d_valid (d_rdata=0) pulsed together, then IDLE.
  - Repeat with the ack landing on the expiry cycle: the ack wins, err stays 0.
- m_ack pulsed while IDLE with no requests: no valid pulses, no state change.

Source files
------------

// File: rtl/risci_mem_arbiter.sv
// risci_mem_arbiter: fetch/data arbiter and sequencer for the core's single shared memory port.
// Define RISCI_ARB_TIMEOUT_EN to build in the bus watchdog that abandons a stalled transaction.
module risci_mem_arbiter #(
  parameter int VLEN       = 64,
  parameter int DLEN       = 64,
  parameter int ILEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [VLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_valid,
  output logic [ILEN-1:0] i_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [VLEN-1:0] d_addr,
  input  logic [DLEN-1:0] d_wdata,
  input  logic [1:0]      d_len,
  output logic            d_gnt,
  output logic            d_valid,
  output logic [DLEN-1:0] d_rdata,
  output logic [VLEN-1:0] m_addr,
  output logic            m_re,
  output logic            m_we,
  output logic [DLEN-1:0] m_wdata,
  output logic [1:0]      m_len,
  input  logic [DLEN-1:0] m_rdata,
  input  logic            m_ack,
  output logic            err
);

  if (DLEN != 2 * ILEN || STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 2 || TIMEOUT > 255)
  begin : gBadParams
    $error("risci_mem_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e          state_q, state_d;
  logic [3:0]      starveCnt_q, starveCnt_d;
  logic            starving, iGrant, dGrant, busyDone, timeoutHit;
  logic [VLEN-1:0] mAddr_q;
  logic [DLEN-1:0] mWdata_q, dRdata_q;
  logic [1:0]      mLen_q;
  logic            mRe_q, mWe_q, iValid_q, dValid_q;
  logic [ILEN-1:0] iData_q;

  assign starving = i_req && (starveCnt_q == 4'(STARVE_MAX));
  assign busyDone = (state_q != IDLE) && (m_ack || timeoutHit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    case (state_q)
      IDLE: begin
        if (dGrant)      state_d = BUSY_D;
        else if (iGrant) state_d = BUSY_I;
        // Only consecutive data wins over a waiting fetch count toward starvation.
        if (dGrant && i_req)
          starveCnt_d = starving ? starveCnt_q : starveCnt_q + 4'd1;
        else if (iGrant || !i_req)
          starveCnt_d = '0;
      end
      BUSY_I, BUSY_D: if (busyDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are Mealy outputs, suppressed while reset is held so all outputs read 0.
  always_comb begin
    iGrant = 1'b0;
    dGrant = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (d_req && !starving) dGrant = 1'b1;
      else if (i_req)         iGrant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mAddr_q  <= '0;
      mWdata_q <= '0;
      mLen_q   <= '0;
      mRe_q    <= 1'b0;
      mWe_q    <= 1'b0;
      iValid_q <= 1'b0;
      dValid_q <= 1'b0;
      iData_q  <= '0;
      dRdata_q <= '0;
    end else begin
      iValid_q <= 1'b0;
      dValid_q <= 1'b0;
      if (iGrant) begin
        mAddr_q <= i_addr;
        mLen_q  <= 2'b10;
        mRe_q   <= 1'b1;
        mWe_q   <= 1'b0;
      end else if (dGrant) begin
        mAddr_q  <= d_addr;
        mWdata_q <= d_wdata;
        mLen_q   <= d_len;
        mRe_q    <= !d_we;
        mWe_q    <= d_we;
      end else if (busyDone) begin
        mRe_q <= 1'b0;
        mWe_q <= 1'b0;
        // A watchdog expiry still completes the owner's request, with zero data.
        if (state_q == BUSY_I) begin
          iValid_q <= 1'b1;
          if (timeoutHit)      iData_q <= '0;
          else if (mAddr_q[2]) iData_q <= m_rdata[DLEN-1:ILEN];
          else                 iData_q <= m_rdata[ILEN-1:0];
        end else begin
          dValid_q <= 1'b1;
          dRdata_q <= (timeoutHit || mWe_q) ? '0 : m_rdata;
        end
      end
    end
  end

`ifdef RISCI_ARB_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       err_q;

  // An ack landing on the expiry cycle wins, so the timeout is masked by m_ack.
  assign timeoutHit = (state_q != IDLE) && !m_ack && (wdog_q == 8'(TIMEOUT - 1));
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeoutHit;
      if (iGrant || dGrant)     wdog_q <= '0;
      else if (state_q != IDLE) wdog_q <= wdog_q + 8'd1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

  assign i_gnt   = iGrant;
  assign d_gnt   = dGrant;
  assign i_valid = iValid_q;
  assign i_data  = iData_q;
  assign d_valid = dValid_q;
  assign d_rdata = dRdata_q;
  assign m_addr  = mAddr_q;
  assign m_re    = mRe_q;
  assign m_we    = mWe_q;
  assign m_wdata = mWdata_q;
  assign m_len   = mLen_q;

endmodule

// File: tb/tb_risci_mem_arbiter.sv
// tb_risci_mem_arbiter: directed, table-driven bench for risci_mem_arbiter.
// Watchdog sequences are compiled in when RISCI_ARB_TIMEOUT_EN is defined.
module tb_risci_mem_arbiter;

  localparam int VLEN = 64, DLEN = 64, ILEN = 32, STARVE_MAX = 4, TIMEOUT = 16;

  localparam logic [63:0] RD_A  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] WD_S  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] RD_L  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] RD_F  = 64'h5555_6666_7777_8888;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_req, i_gnt, i_valid;
  logic [VLEN-1:0] i_addr;
  logic [ILEN-1:0] i_data;
  logic            d_req, d_we, d_gnt, d_valid;
  logic [VLEN-1:0] d_addr;
  logic [DLEN-1:0] d_wdata, d_rdata;
  logic [1:0]      d_len;
  logic [VLEN-1:0] m_addr;
  logic            m_re, m_we, m_ack, err;
  logic [DLEN-1:0] m_wdata, m_rdata;
  logic [1:0]      m_len;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  risci_mem_arbiter #(
    .VLEN(VLEN), .DLEN(DLEN), .ILEN(ILEN), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata), .m_len(m_len),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  typedef struct {
    string       name;
    logic        iReq;
    logic [63:0] iAddr;
    logic        dReq, dWe;
    logic [63:0] dAddr, dWdata;
    logic [1:0]  dLen;
    logic        mAck;
    logic [63:0] mRdata;
    logic        eIGnt, eDGnt, eIValid, eDValid, eMRe, eMWe, eErr;
    logic [31:0] eIData;
    logic [63:0] eDRdata, eMAddr, eMWdata;
    logic [1:0]  eMLen;
  } vec_t;

  vec_t vecs[$];

  // All-zero vector: idle inputs and the post-reset output state.
  function automatic vec_t zeroVec(input string name);
    vec_t v;
    v.name = name;
    v.iReq = 1'b0; v.iAddr = '0; v.dReq = 1'b0; v.dWe = 1'b0;
    v.dAddr = '0; v.dWdata = '0; v.dLen = '0; v.mAck = 1'b0; v.mRdata = '0;
    v.eIGnt = 1'b0; v.eDGnt = 1'b0; v.eIValid = 1'b0; v.eDValid = 1'b0;
    v.eMRe = 1'b0; v.eMWe = 1'b0; v.eErr = 1'b0;
    v.eIData = '0; v.eDRdata = '0; v.eMAddr = '0; v.eMWdata = '0; v.eMLen = '0;
    return v;
  endfunction

  // Next cycle's vector: inputs and pulses return to 0, held data outputs carry over.
  function automatic vec_t carry(input vec_t p, input string name);
    vec_t v;
    v = zeroVec(name);
    v.eIData = p.eIData; v.eDRdata = p.eDRdata;
    v.eMAddr = p.eMAddr; v.eMWdata = p.eMWdata; v.eMLen = p.eMLen;
    return v;
  endfunction

  task automatic driveIdle();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_len = '0; m_ack = 1'b0; m_rdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    i_req = v.iReq; i_addr = v.iAddr; d_req = v.dReq; d_we = v.dWe;
    d_addr = v.dAddr; d_wdata = v.dWdata; d_len = v.dLen;
    m_ack = v.mAck; m_rdata = v.mRdata;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.name, " i_gnt"},   64'(i_gnt),   64'(v.eIGnt));
    checkOutput({v.name, " d_gnt"},   64'(d_gnt),   64'(v.eDGnt));
    checkOutput({v.name, " i_valid"}, 64'(i_valid), 64'(v.eIValid));
    checkOutput({v.name, " d_valid"}, 64'(d_valid), 64'(v.eDValid));
    checkOutput({v.name, " m_re"},    64'(m_re),    64'(v.eMRe));
    checkOutput({v.name, " m_we"},    64'(m_we),    64'(v.eMWe));
    checkOutput({v.name, " err"},     64'(err),     64'(v.eErr));
    checkOutput({v.name, " i_data"},  64'(i_data),  64'(v.eIData));
    checkOutput({v.name, " d_rdata"}, d_rdata,      v.eDRdata);
    checkOutput({v.name, " m_addr"},  m_addr,       v.eMAddr);
    checkOutput({v.name, " m_wdata"}, m_wdata,      v.eMWdata);
    checkOutput({v.name, " m_len"},   64'(m_len),   64'(v.eMLen));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic prevData;

    // Single-cycle vectors covering fetch, store, load, back-to-back and stray ack.
    v = zeroVec("reset"); vecs.push_back(v);
    v = carry(v, "fetchGrant"); v.iReq = 1; v.iAddr = 64'h1004; v.mRdata = RD_A; v.eIGnt = 1;
    vecs.push_back(v);
    v = carry(v, "fetchBusy"); v.mRdata = RD_A; v.eMRe = 1; v.eMAddr = 64'h1004; v.eMLen = 2'b10;
    vecs.push_back(v);
    v = carry(v, "fetchAck"); v.mAck = 1; v.mRdata = RD_A; v.eMRe = 1; vecs.push_back(v);
    v = carry(v, "fetchValid"); v.eIValid = 1; v.eIData = 32'hAAAABBBB; vecs.push_back(v);
    v = carry(v, "storeGrant"); v.dReq = 1; v.dWe = 1; v.dAddr = 64'h2000; v.dWdata = WD_S;
    v.dLen = 2'b11; v.eDGnt = 1; vecs.push_back(v);
    v = carry(v, "storeAck"); v.mAck = 1; v.mRdata = RD_A; v.eMWe = 1; v.eMAddr = 64'h2000;
    v.eMWdata = WD_S; v.eMLen = 2'b11; vecs.push_back(v);
    v = carry(v, "storeValidLoadGrant"); v.dReq = 1; v.dAddr = 64'h3008; v.dWdata = 64'hDEAD;
    v.dLen = 2'b01; v.eDValid = 1; v.eDRdata = '0; v.eDGnt = 1; vecs.push_back(v);
    v = carry(v, "loadAck"); v.mAck = 1; v.mRdata = RD_L; v.eMRe = 1; v.eMAddr = 64'h3008;
    v.eMWdata = 64'hDEAD; v.eMLen = 2'b01; vecs.push_back(v);
    v = carry(v, "loadValidFetchGrant"); v.iReq = 1; v.iAddr = 64'h2000; v.eDValid = 1;
    v.eDRdata = RD_L; v.eIGnt = 1; vecs.push_back(v);
    v = carry(v, "fetchLoAck"); v.mAck = 1; v.mRdata = RD_A; v.eMRe = 1; v.eMAddr = 64'h2000;
    v.eMLen = 2'b10; vecs.push_back(v);
    v = carry(v, "fetchLoValid"); v.eIValid = 1; v.eIData = 32'hCCCCDDDD; vecs.push_back(v);
    v = carry(v, "idleAck"); v.mAck = 1; v.mRdata = RD_F; vecs.push_back(v);
    v = carry(v, "idleQuiet"); vecs.push_back(v);
    v = carry(v, "fetch3Grant"); v.iReq = 1; v.iAddr = 64'h10; v.eIGnt = 1; vecs.push_back(v);
    v = carry(v, "fetch3Ack"); v.mAck = 1; v.mRdata = RD_F; v.eMRe = 1; v.eMAddr = 64'h10;
    v.eMLen = 2'b10; vecs.push_back(v);
    v = carry(v, "fetch3Valid"); v.eIValid = 1; v.eIData = 32'h77778888; vecs.push_back(v);

    rst = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(vecs[i]);
      nextCycle();
    end

    // Both requesters pending: four data grants, then fetch, then data again once cleared.
    driveIdle();
    prevData = 1'b0;
    for (int n = 0; n < 6; n++) begin
      logic expData;
      expData = (n != 4);
      i_req = 1'b1; i_addr = 64'h40; d_req = 1'b1; d_we = 1'b0;
      d_addr = 64'h100 + 64'(n); m_ack = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("starve%0d d_gnt", n), 64'(d_gnt), 64'(expData));
      checkOutput($sformatf("starve%0d i_gnt", n), 64'(i_gnt), 64'(!expData));
      if (n > 0) begin
        checkOutput($sformatf("starve%0d d_valid", n), 64'(d_valid), 64'(prevData));
        checkOutput($sformatf("starve%0d i_valid", n), 64'(i_valid), 64'(!prevData));
      end
      nextCycle();
      d_req = 1'b0; m_ack = 1'b1; m_rdata = 64'h100 + 64'(n);
      nextCycle();
      prevData = expData;
    end
    driveIdle();
    @(negedge clk);
    checkOutput("starve5 d_valid", 64'(d_valid), 64'd1);
    checkOutput("starve5 d_rdata", d_rdata, 64'h105);
    nextCycle();

`ifdef RISCI_ARB_TIMEOUT_EN
    // Load with no ack: err and d_valid pulse together after TIMEOUT busy cycles.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h700;
    @(negedge clk);
    checkOutput("wdog d_gnt", 64'(d_gnt), 64'd1);
    nextCycle();
    driveIdle();
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      checkOutput($sformatf("wdog c%0d err", c), 64'(err), 64'd0);
      checkOutput($sformatf("wdog c%0d d_valid", c), 64'(d_valid), 64'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("wdog expire err", 64'(err), 64'd1);
    checkOutput("wdog expire d_valid", 64'(d_valid), 64'd1);
    checkOutput("wdog expire d_rdata", d_rdata, 64'd0);
    checkOutput("wdog expire m_re", 64'(m_re), 64'd0);
    nextCycle();
    i_req = 1'b1; i_addr = 64'h80;
    @(negedge clk);
    checkOutput("wdog after err", 64'(err), 64'd0);
    checkOutput("wdog after i_gnt", 64'(i_gnt), 64'd1);
    nextCycle();
    i_req = 1'b0; m_ack = 1'b1; m_rdata = RD_A;
    nextCycle();
    driveIdle();
    nextCycle();

    // Ack landing on the expiry cycle wins: real data, no err.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h708;
    nextCycle();
    driveIdle();
    for (int c = 1; c < TIMEOUT; c++) nextCycle();
    m_ack = 1'b1; m_rdata = 64'h0BAD_F00D;
    nextCycle();
    driveIdle();
    @(negedge clk);
    checkOutput("wdog race err", 64'(err), 64'd0);
    checkOutput("wdog race d_valid", 64'(d_valid), 64'd1);
    checkOutput("wdog race d_rdata", d_rdata, 64'h0BAD_F00D);
    nextCycle();
`endif

    // Reset during BUSY_D with an ack one cycle later: transaction abandoned.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
    @(negedge clk);
    checkOutput("rstmid d_gnt", 64'(d_gnt), 64'd1);
    nextCycle();
    d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid busy m_re", 64'(m_re), 64'd1);
    nextCycle();
    rst = 1'b0; m_ack = 1'b1; m_rdata = RD_L;
    @(negedge clk);
    checkOutput("rstmid m_re", 64'(m_re), 64'd0);
    checkOutput("rstmid m_we", 64'(m_we), 64'd0);
    checkOutput("rstmid m_addr", m_addr, 64'd0);
    checkOutput("rstmid d_rdata", d_rdata, 64'd0);
    nextCycle();
    driveIdle();
    i_req = 1'b1; i_addr = 64'h44;
    @(negedge clk);
    checkOutput("rstmid late d_valid", 64'(d_valid), 64'd0);
    checkOutput("rstmid late m_re", 64'(m_re), 64'd0);
    checkOutput("rstmid idle i_gnt", 64'(i_gnt), 64'd1);
    nextCycle();
    i_req = 1'b0; m_ack = 1'b1; m_rdata = RD_A;
    nextCycle();
    driveIdle();
    @(negedge clk);
    checkOutput("rstmid fetch i_valid", 64'(i_valid), 64'd1);
    checkOutput("rstmid fetch i_data", 64'(i_data), 64'hAAAABBBB);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
